// File: rtl/mcif_write_eg_pkg.sv
// Shared constants for the MCIF write-egress stage: client thread ids,
// context-queue entry field positions and sticky error bit indices.
package mcif_write_eg_pkg;

  // Client thread ids carried in the low nibble of the B-channel id
  localparam int SDP_TID = 1;
  localparam int PDP_TID = 2;
  localparam int CDP_TID = 3;

  // Context-queue entry layout: {require_ack, axi_len[1:0]}
  localparam int ACK_BIT = 2;
  localparam int LEN_MSB = 1;
  localparam int LEN_LSB = 0;

  // Sticky error status bit positions
  localparam int ERR_BRESP = 0;
  localparam int ERR_TID   = 1;

endpackage

// File: rtl/mcif_write_eg.sv
// MCIF write egress: accepts AXI B responses, pops the matching per-thread
// context entry, returns burst length credit to ingress and pulses the
// per-client write-complete strobes.
module mcif_write_eg
  import mcif_write_eg_pkg::*;
#(
  parameter int NTHR = 4,
  parameter int CQW  = 3
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 noc2mcif_axi_b_bvalid,
  output logic                 noc2mcif_axi_b_bready,
  input  logic [7:0]           noc2mcif_axi_b_bid,
  input  logic [1:0]           noc2mcif_axi_b_bresp,
  input  logic [NTHR-1:0]      cq_rd_pvld,
  output logic [NTHR-1:0]      cq_rd_prdy,
  input  logic [NTHR*CQW-1:0]  cq_rd_pd,
  output logic                 eg2ig_axi_vld,
  output logic [1:0]           eg2ig_axi_len,
  output logic                 mcif2sdp_wr_rsp_complete,
  output logic                 mcif2pdp_wr_rsp_complete,
  output logic                 mcif2cdp_wr_rsp_complete,
  output logic [1:0]           eg_err_status
);

  logic           vld_p1;
  logic [3:0]     tid_p1;
  logic [1:0]     bresp_p1;

  logic           tid_legal;
  logic           sel_pvld;
  logic [CQW-1:0] sel_entry;
  logic           retire;
  logic           pop;
  logic           b_hs;

  // Upper id bits carry no meaning for thread selection
  logic unused_bid_hi;
  assign unused_bid_hi = ^noc2mcif_axi_b_bid[7:4];

  assign tid_legal = int'(tid_p1) < NTHR;

  // Select the head entry and pop strobe of the thread addressed by S1
  always_comb begin
    sel_pvld   = 1'b0;
    sel_entry  = '0;
    cq_rd_prdy = '0;
    for (int t = 0; t < NTHR; t++) begin
      if (tid_p1 == 4'(t)) begin
        sel_pvld      = cq_rd_pvld[t];
        sel_entry     = cq_rd_pd[t*CQW +: CQW];
        cq_rd_prdy[t] = vld_p1 && cq_rd_pvld[t];
      end
    end
  end

  // Illegal ids retire at once; legal ids wait for their context entry
  assign retire                = vld_p1 && (!tid_legal || sel_pvld);
  assign pop                   = vld_p1 && tid_legal && sel_pvld;
  assign noc2mcif_axi_b_bready = !vld_p1 || retire;
  assign b_hs                  = noc2mcif_axi_b_bvalid && noc2mcif_axi_b_bready;

  // ---- S1 boundary: response register (valid reset, payload free-running)
  // S1 occupancy: load on handshake, drain on retire
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      vld_p1 <= 1'b0;
    end else if (b_hs) begin
      vld_p1 <= 1'b1;
    end else if (retire) begin
      vld_p1 <= 1'b0;
    end
  end

  // S1 payload capture; meaningful only while vld_p1 is set
  always_ff @(posedge nvdla_core_clk) begin
    if (b_hs) begin
      tid_p1   <= noc2mcif_axi_b_bid[3:0];
      bresp_p1 <= noc2mcif_axi_b_bresp;
    end
  end

  // ---- S2 boundary: registered credit, complete pulses and error status
  // Registered outputs for the beat retired this cycle
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      eg2ig_axi_vld            <= 1'b0;
      eg2ig_axi_len            <= 2'b00;
      mcif2sdp_wr_rsp_complete <= 1'b0;
      mcif2pdp_wr_rsp_complete <= 1'b0;
      mcif2cdp_wr_rsp_complete <= 1'b0;
      eg_err_status            <= 2'b00;
    end else begin
      eg2ig_axi_vld            <= pop;
      if (pop) begin
        eg2ig_axi_len <= sel_entry[LEN_MSB:LEN_LSB];
      end
      mcif2sdp_wr_rsp_complete <= pop && sel_entry[ACK_BIT] && (tid_p1 == 4'(SDP_TID));
      mcif2pdp_wr_rsp_complete <= pop && sel_entry[ACK_BIT] && (tid_p1 == 4'(PDP_TID));
      mcif2cdp_wr_rsp_complete <= pop && sel_entry[ACK_BIT] && (tid_p1 == 4'(CDP_TID));
      if (pop && (bresp_p1 != 2'b00)) begin
        eg_err_status[ERR_BRESP] <= 1'b1;
      end
      if (retire && !tid_legal) begin
        eg_err_status[ERR_TID] <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  logic       pop_q;
  logic       stall_q;
  logic [7:0] bid_q;

  // Simulation-only history for protocol checks
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      pop_q   <= 1'b0;
      stall_q <= 1'b0;
      bid_q   <= 8'h00;
    end else begin
      pop_q   <= pop;
      stall_q <= noc2mcif_axi_b_bvalid && !noc2mcif_axi_b_bready;
      bid_q   <= noc2mcif_axi_b_bid;
    end
  end

  // Protocol assertions: one-hot pop, one credit per retire, stable stalled id
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rstn) begin
      assert ($onehot0(cq_rd_prdy))
        else $error("cq_rd_prdy not one-hot: %b", cq_rd_prdy);
      assert (!eg2ig_axi_vld || pop_q)
        else $error("eg2ig_axi_vld without a retire");
      assert (!(stall_q && noc2mcif_axi_b_bvalid) || (noc2mcif_axi_b_bid == bid_q))
        else $error("bid changed while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_mcif_write_eg.sv
// Self-checking bench for mcif_write_eg: scoreboard of expected credit and
// complete pulses, checked by a monitor on the falling clock edge.
module tb_mcif_write_eg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        b_bvalid = 1'b0;
  logic        b_bready;
  logic [7:0]  b_bid = 8'h00;
  logic [1:0]  b_bresp = 2'b00;
  logic [3:0]  pvld = 4'b0000;
  logic [3:0]  prdy;
  logic [11:0] pd = 12'h000;
  logic        ig_vld;
  logic [1:0]  ig_len;
  logic        sdp_cmp, pdp_cmp, cdp_cmp;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;
  int run   = 0;
  int max_run = 0;

  typedef struct {
    logic [1:0] len;
    logic       sdp;
    logic       pdp;
    logic       cdp;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mcif_write_eg #(.NTHR(4), .CQW(3)) dut (
    .nvdla_core_clk           (clk),
    .nvdla_core_rstn          (rst_n),
    .noc2mcif_axi_b_bvalid    (b_bvalid),
    .noc2mcif_axi_b_bready    (b_bready),
    .noc2mcif_axi_b_bid       (b_bid),
    .noc2mcif_axi_b_bresp     (b_bresp),
    .cq_rd_pvld               (pvld),
    .cq_rd_prdy               (prdy),
    .cq_rd_pd                 (pd),
    .eg2ig_axi_vld            (ig_vld),
    .eg2ig_axi_len            (ig_len),
    .mcif2sdp_wr_rsp_complete (sdp_cmp),
    .mcif2pdp_wr_rsp_complete (pdp_cmp),
    .mcif2cdp_wr_rsp_complete (cdp_cmp),
    .eg_err_status            (err)
  );

  // Expected output event for a legal thread retiring the given entry
  function automatic exp_t mk_exp(input int tid, input logic [2:0] e);
    exp_t x;
    x.len = e[1:0];
    x.sdp = e[2] && (tid == 1);
    x.pdp = e[2] && (tid == 2);
    x.cdp = e[2] && (tid == 3);
    return x;
  endfunction

  // Monitor: every credit pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (ig_vld) begin
        exp_t x;
        run++;
        if (run > max_run) max_run = run;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: vld=1 len=%0d with no expected pulse", ig_len);
        end else begin
          x = exp_q.pop_front();
          if ({ig_len, sdp_cmp, pdp_cmp, cdp_cmp} !== {x.len, x.sdp, x.pdp, x.cdp}) begin
            bad++;
            $display("FAIL sb_pulse: got len=%0d s/p/c=%b%b%b want len=%0d s/p/c=%b%b%b",
                     ig_len, sdp_cmp, pdp_cmp, cdp_cmp, x.len, x.sdp, x.pdp, x.cdp);
          end
        end
      end else begin
        run = 0;
        if (sdp_cmp || pdp_cmp || cdp_cmp) begin
          total++;
          bad++;
          $display("FAIL sb_stray_complete: s/p/c=%b%b%b without vld", sdp_cmp, pdp_cmp, cdp_cmp);
        end
      end
    end
  end

  // Present one B beat and hold it until accepted (bounded)
  task automatic send_b(input logic [7:0] id, input logic [1:0] rsp);
    int  n  = 0;
    bit  ok = 1'b0;
    b_bid    = id;
    b_bresp  = rsp;
    b_bvalid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = b_bready;
      @(posedge clk);
      n++;
    end
    #1 b_bvalid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_b_timeout: bid=%h never accepted, want accept within 50 cycles", id);
    end
  endtask

  // Wait for the scoreboard to empty (bounded)
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d pulses outstanding, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({b_bready, prdy, ig_vld, ig_len, sdp_cmp, pdp_cmp, cdp_cmp, err} !== {1'b1, 4'b0, 1'b0, 2'b0, 3'b0, 2'b0}) begin
      bad++;
      $display("FAIL reset_state: bready=%b prdy=%b vld=%b len=%0d cmp=%b%b%b err=%b, want bready=1 rest 0",
               b_bready, prdy, ig_vld, ig_len, sdp_cmp, pdp_cmp, cdp_cmp, err);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    pvld = 4'b0010;
    pd   = {3'b000, 3'b000, 3'b111, 3'b000};
    exp_q.push_back(mk_exp(1, 3'b111));
    send_b(8'h01, 2'b00);
    @(negedge clk);
    total++;
    if (prdy !== 4'b0010) begin
      bad++;
      $display("FAIL basic_prdy: prdy=%b want 0010", prdy);
    end
    @(negedge clk);
    total++;
    if ({ig_vld, ig_len, sdp_cmp} !== {1'b1, 2'd3, 1'b1}) begin
      bad++;
      $display("FAIL basic_latency: vld=%b len=%0d sdp=%b want 1 3 1", ig_vld, ig_len, sdp_cmp);
    end
    drain("basic");
  endtask

  task automatic test_no_ack();
    pvld = 4'b1000;
    pd   = {3'b001, 3'b000, 3'b000, 3'b000};
    exp_q.push_back(mk_exp(3, 3'b001));
    send_b(8'h03, 2'b00);
    drain("no_ack");
  endtask

  task automatic test_cq_stall();
    pvld = 4'b1000;
    pd   = {3'b101, 3'b110, 3'b000, 3'b000};
    exp_q.push_back(mk_exp(2, 3'b110));
    exp_q.push_back(mk_exp(3, 3'b101));
    b_bid    = 8'h02;
    b_bresp  = 2'b00;
    b_bvalid = 1'b1;
    @(posedge clk);
    #1 b_bid = 8'h03;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({b_bready, prdy, ig_vld} !== {1'b0, 4'b0000, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold: cyc=%0d bready=%b prdy=%b vld=%b want 0 0000 0", i, b_bready, prdy, ig_vld);
      end
      @(posedge clk);
      #1;
    end
    pvld = 4'b1100;
    @(negedge clk);
    total++;
    if ({b_bready, prdy} !== {1'b1, 4'b0100}) begin
      bad++;
      $display("FAIL stall_release: bready=%b prdy=%b want 1 0100", b_bready, prdy);
    end
    @(posedge clk);
    #1 b_bvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({ig_vld, ig_len} !== {1'b1, 2'd2}) begin
      bad++;
      $display("FAIL stall_out: vld=%b len=%0d want 1 2", ig_vld, ig_len);
    end
    drain("cq_stall");
  endtask

  task automatic test_back_to_back();
    logic [7:0] ids [3] = '{8'h01, 8'h02, 8'h03};
    logic [2:0] ent [4];
    ent[0] = 3'b000; ent[1] = 3'b111; ent[2] = 3'b010; ent[3] = 3'b101;
    pvld    = 4'b1110;
    pd      = {ent[3], ent[2], ent[1], ent[0]};
    max_run = 0;
    b_bresp = 2'b00;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk_exp(int'(ids[i % 3]), ent[ids[i % 3]]));
      b_bid    = ids[i % 3];
      b_bvalid = 1'b1;
      @(negedge clk);
      total++;
      if (b_bready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_bready: beat=%0d bready=%b want 1", i, b_bready);
      end
      @(posedge clk);
      #1;
    end
    b_bvalid = 1'b0;
    drain("back_to_back");
    total++;
    if (max_run != 8) begin
      bad++;
      $display("FAIL b2b_consecutive: longest vld run=%0d want 8", max_run);
    end
  endtask

  task automatic test_errors();
    pvld = 4'b1110;
    pd   = {3'b101, 3'b110, 3'b111, 3'b000};
    send_b(8'h07, 2'b00);
    @(negedge clk);
    total++;
    if ({prdy, b_bready} !== {4'b0000, 1'b1}) begin
      bad++;
      $display("FAIL err_tid_pop: prdy=%b bready=%b want 0000 1", prdy, b_bready);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (ig_vld !== 1'b0) begin
        bad++;
        $display("FAIL err_tid_vld: vld=%b want 0", ig_vld);
      end
    end
    total++;
    if (err !== 2'b10) begin
      bad++;
      $display("FAIL err_tid_status: err=%b want 10", err);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(mk_exp(1, 3'b111));
    send_b(8'h01, 2'b10);
    drain("err_bresp");
    total++;
    if (err !== 2'b11) begin
      bad++;
      $display("FAIL err_bresp_status: err=%b want 11", err);
    end
  endtask

  task automatic test_reset_mid();
    pvld = 4'b0000;
    pd   = {3'b111, 3'b111, 3'b111, 3'b000};
    send_b(8'h01, 2'b00);
    @(negedge clk);
    total++;
    if (b_bready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_held: bready=%b want 0", b_bready);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({b_bready, err, ig_vld} !== {1'b1, 2'b00, 1'b0}) begin
      bad++;
      $display("FAIL rmid_async: bready=%b err=%b vld=%b want 1 00 0", b_bready, err, ig_vld);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pvld = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({ig_vld, prdy, b_bready, err} !== {1'b0, 4'b0000, 1'b1, 2'b00}) begin
        bad++;
        $display("FAIL rmid_after: vld=%b prdy=%b bready=%b err=%b want 0 0000 1 00",
                 ig_vld, prdy, b_bready, err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_ack();
    test_cq_stall();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_queue: %0d outstanding, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
